// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns execute-stage load/store requests into word-wide
// dcache reads and writes, with read-modify-write sub-word stores and load extension.
module dmem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [XLEN-1:0] dcache_addr_o,
  output logic            dcache_read_en_o,
  output logic            dcache_write_en_o,
  output logic [XLEN-1:0] dcache_write_data_o,
  input  logic [XLEN-1:0] dcache_read_data_i
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    RESP
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic misaligned;
  logic illegal;

  // Select the addressed lane of the read word and extend it to XLEN.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      f3,
                                                  input logic [1:0]      lane,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    return {{(XLEN-8){b[7]}}, b};
      F3_BU:   return {{(XLEN-8){1'b0}}, b};
      F3_H:    return {{(XLEN-16){h[15]}}, h};
      F3_HU:   return {{(XLEN-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  // Overwrite only the lanes a sub-word store targets; other bytes keep the old word.
  function automatic logic [XLEN-1:0] merge_store(input logic            is_half,
                                                  input logic [1:0]      lane,
                                                  input logic [XLEN-1:0] old_word,
                                                  input logic [15:0]     new_data);
    logic [XLEN-1:0] w;
    w = old_word;
    if (is_half) w[{lane[1], 4'b0000} +: 16] = new_data;
    else         w[{lane, 3'b000} +: 8]      = new_data[7:0];
    return w;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (req_funct3_i)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = req_addr_i[0];
      F3_W:        misaligned = |req_addr_i[1:0];
      default:     illegal    = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (req_we_i && req_funct3_i[2]) illegal = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= IDLE;
      req_ready_o         <= 1'b1;
      resp_valid_o        <= 1'b0;
      resp_rdata_o        <= '0;
      resp_err_o          <= 1'b0;
      dcache_addr_o       <= '0;
      dcache_read_en_o    <= 1'b0;
      dcache_write_en_o   <= 1'b0;
      dcache_write_data_o <= '0;
      we_q                <= 1'b0;
      f3_q                <= '0;
      lane_q              <= '0;
      wdata_q             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            we_q        <= req_we_i;
            f3_q        <= req_funct3_i;
            lane_q      <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i[15:0];
            req_ready_o <= 1'b0;
            if (misaligned || illegal) begin
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
              state        <= RESP;
            end else begin
              dcache_addr_o <= {2'b00, req_addr_i[XLEN-1:2]};
              if (req_we_i && req_funct3_i == F3_W) begin
                dcache_write_en_o   <= 1'b1;
                dcache_write_data_o <= req_wdata_i;
                state               <= WR;
              end else begin
                dcache_read_en_o <= 1'b1;
                state            <= RD;
              end
            end
          end
        end
        RD: begin
          dcache_read_en_o <= 1'b0;
          state            <= RDW;
        end
        RDW: begin
          if (we_q) begin
            dcache_write_data_o <= merge_store(f3_q[0], lane_q, dcache_read_data_i, wdata_q);
            dcache_write_en_o   <= 1'b1;
            state               <= WR;
          end else begin
            resp_rdata_o  <= extend_load(f3_q, lane_q, dcache_read_data_i);
            resp_valid_o  <= 1'b1;
            dcache_addr_o <= '0;
            state         <= RESP;
          end
        end
        WR: begin
          dcache_write_en_o   <= 1'b0;
          dcache_write_data_o <= '0;
          dcache_addr_o       <= '0;
          resp_valid_o        <= 1'b1;
          resp_rdata_o        <= '0;
          state               <= RESP;
        end
        RESP: begin
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= '0;
          req_ready_o  <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
